// File: rtl/pixel_frame_sequencer.sv
// rtl/pixel_frame_sequencer.sv - double-buffered frame source streaming scaled colours to pixel_driver
module pixel_frame_sequencer #(
    parameter int NUM_PIXELS = 3,
    parameter int FRAME_DIV  = 266_666,
    parameter int AW         = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_data,
    input  logic          swap_req,
    input  logic [7:0]    brightness,
    input  logic          px_ready,
    output logic          px_valid,
    output logic [23:0]   px_color,
    output logic          px_reset,
    output logic          busy,
    output logic          swap_done,
    output logic          overrun
);
    localparam int            CW       = $clog2(FRAME_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_LATCH} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [23:0]   r_bank0 [NUM_PIXELS];
    logic [23:0]   r_bank1 [NUM_PIXELS];
    logic          r_front;
    logic          r_pend;
    logic          r_swap_pend;
    logic          r_overrun;
    logic          r_swap_done;
    logic [CW-1:0] r_tick_cnt;
    logic [AW-1:0] r_idx;
    logic [7:0]    r_bri;
    logic          r_valid;
    logic          r_reset;
    logic [23:0]   r_color;
    logic          w_tick;
    logic          w_start;
    logic          w_hs;
    logic          w_wr_ok;
    logic [23:0]   w_rd_data;
    logic [23:0]   w_scaled;

    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    assign w_tick    = (r_tick_cnt == CNT_LAST);
    assign w_start   = (r_state == S_IDLE) && r_pend;
    assign w_hs      = r_valid && px_ready;
    assign w_wr_ok   = wr_en && (32'(wr_addr) < NUM_PIXELS);
    assign w_rd_data = r_front ? r_bank1[r_idx] : r_bank0[r_idx];
    assign w_scaled  = {scale_ch(w_rd_data[23:16], r_bri),
                        scale_ch(w_rd_data[15:8],  r_bri),
                        scale_ch(w_rd_data[7:0],   r_bri)};

    // Host writes use the registered front, so a write coinciding with a swap lands in the pre-swap back bank.
    always_ff @(posedge CLK) begin
        if (w_wr_ok) begin
            if (r_front) begin
                r_bank0[wr_addr] <= wr_data;
            end else begin
                r_bank1[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tick_cnt  <= '0;
            r_pend      <= 1'b0;
            r_overrun   <= 1'b0;
            r_swap_pend <= 1'b0;
            r_front     <= 1'b0;
            r_swap_done <= 1'b0;
            r_bri       <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) begin
                r_pend <= 1'b1;
            end else if (w_start) begin
                r_pend <= 1'b0;
            end
            if (w_tick && r_pend) begin
                r_overrun <= 1'b1;
            end
            // A request arriving on the start cycle survives the clear and serves the next frame.
            if (swap_req) begin
                r_swap_pend <= 1'b1;
            end else if (w_start) begin
                r_swap_pend <= 1'b0;
            end
            if (w_start && r_swap_pend) begin
                r_front <= ~r_front;
            end
            r_swap_done <= w_start && r_swap_pend;
            if (w_start) begin
                r_bri <= brightness;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_pend) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_SEND;
            S_SEND:  if (w_hs) w_state_nxt = (r_idx == IDX_LAST) ? S_LATCH : S_FETCH;
            S_LATCH: if (w_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_reset <= 1'b0;
            r_color <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pend) r_idx <= '0;
                end
                S_FETCH: begin
                    r_color <= w_scaled;
                    r_valid <= 1'b1;
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (r_idx == IDX_LAST) begin
                            r_reset <= 1'b1;
                            r_color <= '0;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_valid <= 1'b0;
                        end
                    end
                end
                S_LATCH: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        r_reset <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign px_valid  = r_valid;
    assign px_color  = r_color;
    assign px_reset  = r_reset;
    assign busy      = (r_state != S_IDLE);
    assign swap_done = r_swap_done;
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// tb/tb_pixel_frame_sequencer.sv - self-checking bench for pixel_frame_sequencer
module tb_pixel_frame_sequencer;
    localparam int NP = 3;
    localparam int FD = 64;
    localparam int AW = 2;
    localparam logic [24:0] RST_ITEM = 25'h1000000;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = '0;
    logic          swap_req = 1'b0;
    logic [7:0]    brightness = 8'd255;
    logic          px_ready = 1'b1;
    logic          px_valid;
    logic [23:0]   px_color;
    logic          px_reset;
    logic          busy;
    logic          swap_done;
    logic          overrun;

    always #5 CLK = ~CLK;

    pixel_frame_sequencer #(.NUM_PIXELS(NP), .FRAME_DIV(FD), .AW(AW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .brightness(brightness), .px_ready(px_ready), .px_valid(px_valid),
        .px_color(px_color), .px_reset(px_reset), .busy(busy), .swap_done(swap_done), .overrun(overrun)
    );

    typedef struct {
        logic [23:0] color;
        logic [7:0]  bri;
        logic [23:0] exp;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          swap_cnt = 0;
    int          tb_front = 0;
    logic [24:0] act_q[$];
    logic [24:0] exp_q[$];
    vec_t        vecs[8];

    always @(negedge CLK) begin
        if (RESET_N && px_valid && px_ready) act_q.push_back({px_reset, px_color});
        if (RESET_N && swap_done) swap_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] item(input int i);
        if (i < act_q.size()) return act_q[i];
        return 25'h1ffffff;
    endfunction

    function automatic logic [23:0] ref_scale(input logic [23:0] c, input int b);
        int r, g, bl;
        r  = (int'(c[23:16]) * (b + 1)) / 256;
        g  = (int'(c[15:8])  * (b + 1)) / 256;
        bl = (int'(c[7:0])   * (b + 1)) / 256;
        return {8'(r), 8'(g), 8'(bl)};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        wr_en = 1'b0;
        swap_req = 1'b0;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        cyc = 0;
        tb_front = 0;
        act_q.delete();
    endtask

    task automatic write_px(input int addr, input logic [23:0] data);
        wr_en = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        step();
        wr_en = 1'b0;
    endtask

    task automatic write_frame(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
        write_px(0, a);
        write_px(1, b);
        write_px(2, c);
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        tb_front ^= 1;
    endtask

    task automatic wait_items(input int n, input string name);
        int k = 0;
        while (act_q.size() < n && k < 4 * FD) begin
            step();
            k++;
        end
        check({name, "_count"}, act_q.size(), n);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 4 * FD) begin
            step();
            k++;
        end
        check("idle", busy, 0);
    endtask

    task automatic check_latency(input string name);
        int k = 0;
        while (!px_valid && k < FD + 20) begin
            step();
            k++;
        end
        check(name, cyc, FD + 2);
    endtask

    task automatic check_frame(input string name, input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
        check({name, "_px0"}, item(0), {1'b0, a});
        check({name, "_px1"}, item(1), {1'b0, b});
        check({name, "_px2"}, item(2), {1'b0, c});
        check({name, "_latch"}, item(3), RST_ITEM);
    endtask

    initial begin
        int base;
        int pf;
        logic [23:0] mb [2][NP];
        int mfront, mswp, mbri, old, exp_swaps, lowrun;
        logic decision;

        vecs[0] = '{24'hff8040, 8'd127, 24'h7f4020};
        vecs[1] = '{24'hff8040, 8'd0,   24'h000000};
        vecs[2] = '{24'hff8040, 8'd255, 24'hff8040};
        vecs[3] = '{24'h123456, 8'd255, 24'h123456};
        vecs[4] = '{24'hffffff, 8'd128, 24'h808080};
        vecs[5] = '{24'hffffff, 8'd1,   24'h010101};
        vecs[6] = '{24'h804020, 8'd63,  24'h201008};
        vecs[7] = '{24'h00ff80, 8'd200, 24'h00c864};

        // basic frame, reset values, latency, single swap
        do_reset();
        check("rst_valid", px_valid, 0);
        check("rst_color", px_color, 0);
        check("rst_reset", px_reset, 0);
        check("rst_busy", busy, 0);
        check("rst_swap_done", swap_done, 0);
        check("rst_overrun", overrun, 0);
        base = swap_cnt;
        write_frame(24'hff0000, 24'h00ff00, 24'h0000ff);
        pulse_swap();
        check_latency("latency");
        wait_items(4, "basic");
        check_frame("basic", 24'hff0000, 24'h00ff00, 24'h0000ff);
        check("swap_done_once", swap_cnt - base, 1);

        // brightness vectors
        for (int i = 0; i < 8; i++) begin
            wait_idle();
            act_q.delete();
            write_frame(vecs[i].color, vecs[i].color, vecs[i].color);
            brightness = vecs[i].bri;
            pulse_swap();
            wait_items(4, $sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i), vecs[i].exp, vecs[i].exp, vecs[i].exp);
        end

        // backpressure on pixel 1 with a brightness change mid-frame
        wait_idle();
        act_q.delete();
        write_frame(24'hff8040, 24'h123456, 24'habcdef);
        brightness = 8'd255;
        pulse_swap();
        wait_items(1, "bp_first");
        px_ready = 1'b0;
        brightness = 8'd0;
        step();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid%0d", i), px_valid, 1);
            check($sformatf("bp_color%0d", i), px_color, 24'h123456);
            step();
        end
        px_ready = 1'b1;
        wait_items(4, "bp");
        check_frame("bp", 24'hff8040, 24'h123456, 24'habcdef);
        repeat (8) step();
        check("bp_hs_total", act_q.size(), 4);
        brightness = 8'd255;

        // write isolation and out-of-range write
        wait_idle();
        act_q.delete();
        for (int k = 0; k < 2 * FD && !busy; k++) step();
        write_px(0, 24'h010101);
        write_px(1, 24'h020202);
        write_px(2, 24'h030303);
        write_px(3, 24'heeeeee);
        wait_items(4, "iso_cur");
        check_frame("iso_cur", 24'hff8040, 24'h123456, 24'habcdef);
        wait_idle();
        act_q.delete();
        pulse_swap();
        wait_items(4, "iso_new");
        check_frame("iso_new", 24'h010101, 24'h020202, 24'h030303);
        wait_idle();
        act_q.delete();
        pulse_swap();
        wait_items(4, "iso_old");
        check_frame("iso_old", 24'hff8040, 24'h123456, 24'habcdef);

        // overrun under long stall, then back-to-back frame
        wait_idle();
        act_q.delete();
        px_ready = 1'b0;
        check("ovr_before", overrun, 0);
        for (int k = 0; k < 2 * FD && !px_valid; k++) step();
        repeat (2 * FD + 10) step();
        check("ovr_set", overrun, 1);
        px_ready = 1'b1;
        wait_items(4, "ovr");
        check_frame("ovr", 24'hff8040, 24'h123456, 24'habcdef);
        step();
        check("ovr_next_frame", busy, 1);
        check("ovr_sticky", overrun, 1);

        // reset during pixel 1
        wait_idle();
        act_q.delete();
        write_frame(24'h102030, 24'h405060, 24'h708090);
        pulse_swap();
        wait_items(4, "pre_rst");
        check_frame("pre_rst", 24'h102030, 24'h405060, 24'h708090);
        pf = tb_front;
        write_frame(24'ha1a2a3, 24'hb1b2b3, 24'hc1c2c3);
        act_q.delete();
        wait_items(1, "mid_first");
        px_ready = 1'b0;
        step();
        check("mid_valid", px_valid, 1);
        RESET_N = 1'b0;
        #1;
        check("arst_valid", px_valid, 0);
        check("arst_color", px_color, 0);
        check("arst_reset", px_reset, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun, 0);
        check("arst_swap_done", swap_done, 0);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        cyc = 0;
        tb_front = 0;
        act_q.delete();
        px_ready = 1'b1;
        check_latency("rst_latency");
        wait_items(4, "post_rst");
        if (pf == 0) check_frame("post_rst", 24'h102030, 24'h405060, 24'h708090);
        else check_frame("post_rst", 24'ha1a2a3, 24'hb1b2b3, 24'hc1c2c3);

        // randomized traffic against a transaction-level model
        do_reset();
        exp_q.delete();
        base = swap_cnt;
        mfront = 0;
        mswp = 0;
        mbri = 0;
        exp_swaps = 0;
        lowrun = 0;
        for (int n = 0; n < 7 * FD - 4; n++) begin
            if (n < 3) begin
                wr_en = 1'b1; wr_addr = AW'(n); wr_data = 24'($urandom); swap_req = 1'b0;
            end else if (n == 3) begin
                wr_en = 1'b0; swap_req = 1'b1;
            end else if (n >= FD + 1 && n < FD + 4) begin
                wr_en = 1'b1; wr_addr = AW'(n - FD - 1); wr_data = 24'($urandom); swap_req = 1'b0;
            end else if (n < FD + 8) begin
                wr_en = 1'b0; swap_req = 1'b0;
            end else begin
                wr_en = ($urandom_range(0, 3) == 0);
                wr_addr = AW'($urandom_range(0, 3));
                wr_data = 24'($urandom);
                swap_req = ($urandom_range(0, 15) == 0);
            end
            brightness = 8'($urandom);
            px_ready = (lowrun >= 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
            lowrun = px_ready ? 0 : lowrun + 1;

            decision = (n >= FD) && (n % FD == 0);
            old = mfront;
            if (decision) begin
                if (mswp != 0) begin
                    mfront ^= 1;
                    mswp = 0;
                    exp_swaps++;
                end
                mbri = int'(brightness);
            end
            if (wr_en && int'(wr_addr) < NP) mb[1 - old][wr_addr] = wr_data;
            if (swap_req) mswp = 1;
            if (decision) begin
                for (int i = 0; i < NP; i++) exp_q.push_back({1'b0, ref_scale(mb[mfront][i], mbri)});
                exp_q.push_back(RST_ITEM);
            end
            step();
        end
        wr_en = 1'b0;
        swap_req = 1'b0;
        px_ready = 1'b1;
        repeat (4) step();
        check("rnd_count", act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) check($sformatf("rnd_item%0d", i), item(i), exp_q[i]);
        check("rnd_swaps", swap_cnt - base, exp_swaps);
        check("rnd_overrun", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
